// File: rtl/ysyx_040729_idu_stage.sv
// Instruction decode stage: one registered entry between IFU and EXU with a
// valid/ready handshake on both sides, full RV64I(+M) control decode.
module ysyx_040729_idu_stage #(
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned PC_WIDTH   = 64,
    parameter bit          EN_MEXT    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INST_WIDTH-1:0] in_inst,
    input  logic [PC_WIDTH-1:0]   in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic [4:0]            out_rd,
    output logic                  out_rf_we,
    output logic                  out_mem_wen,
    output logic                  out_alu_src2_ri,
    output logic                  out_alu_len_dw,
    output logic                  out_mul_div,
    output logic [2:0]            out_rf_wdata_src,
    output logic [1:0]            out_npc_src,
    output logic [DATA_WIDTH-1:0] out_immediate,
    output logic                  out_ecall,
    output logic                  out_mret,
    output logic                  out_csr_enable,
    output logic                  out_illegal,
    output logic [31:0]           decode_cnt
);

    typedef enum logic [2:0] {
        TY_R, TY_I, TY_S, TY_B, TY_U, TY_J, TY_SYS, TY_X
    } inst_type_e;

    typedef enum logic [6:0] {
        OPC_LUI        = 7'b0110111,
        OPC_AUIPC      = 7'b0010111,
        OPC_JAL        = 7'b1101111,
        OPC_JALR       = 7'b1100111,
        OPC_BRANCH     = 7'b1100011,
        OPC_LOAD       = 7'b0000011,
        OPC_STORE      = 7'b0100011,
        OPC_OP_IMM     = 7'b0010011,
        OPC_OP         = 7'b0110011,
        OPC_OP_IMM_32  = 7'b0011011,
        OPC_OP_32      = 7'b0111011,
        OPC_SYSTEM     = 7'b1110011
    } opcode_e;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [4:0]            rd;
    inst_type_e            d_type;
    logic [2:0]            d_wsrc;
    logic [1:0]            d_npc;
    logic                  d_dw;
    logic                  d_illegal;
    logic                  d_mul;
    logic                  d_rf_we;
    logic                  d_mem_wen;
    logic                  d_src2_ri;
    logic                  d_ecall;
    logic                  d_mret;
    logic                  d_csr;
    logic [31:0]           imm32;
    logic [DATA_WIDTH-1:0] d_imm;
    logic                  fire;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];
    assign rd     = in_inst[11:7];

    assign in_ready = (!out_valid || out_ready) && !flush;
    assign fire     = in_valid && in_ready;

    always_comb begin
        d_type    = TY_X;
        d_wsrc    = '0;
        d_npc     = '0;
        d_dw      = 1'b0;
        d_illegal = 1'b0;
        d_mul     = 1'b0;
        case (opcode)
            OPC_LUI:    begin d_wsrc = 3'd2; d_type = TY_U; end
            OPC_AUIPC:  begin d_wsrc = 3'd4; d_type = TY_U; end
            OPC_JAL:    begin d_wsrc = 3'd5; d_npc = 2'd1; d_type = TY_J; end
            OPC_JALR:   begin d_wsrc = 3'd5; d_npc = 2'd2; d_type = TY_I; end
            OPC_BRANCH: begin d_npc = 2'd3; d_type = TY_B; end
            OPC_LOAD:   begin d_wsrc = 3'd1; d_type = TY_I; end
            OPC_STORE:  d_type = TY_S;
            OPC_OP_IMM: d_type = TY_I;
            OPC_OP_IMM_32: begin
                d_dw   = 1'b1;
                d_type = TY_I;
                if (DATA_WIDTH == 32) d_illegal = 1'b1;
            end
            OPC_OP, OPC_OP_32: begin
                d_type = TY_R;
                if (opcode == OPC_OP_32) begin
                    d_dw = 1'b1;
                    if (DATA_WIDTH == 32) d_illegal = 1'b1;
                end
                if (funct7 == 7'b0000001) begin
                    if (EN_MEXT) d_mul = 1'b1;
                    else         d_illegal = 1'b1;
                end
            end
            OPC_SYSTEM: d_type = TY_SYS;
            default:    d_illegal = 1'b1;
        endcase
        if (in_inst[1:0] != 2'b11) d_illegal = 1'b1;

        d_rf_we   = 1'b0;
        d_mem_wen = 1'b0;
        d_src2_ri = 1'b0;
        imm32     = '0;
        case (d_type)
            TY_R:   d_rf_we = 1'b1;
            TY_I: begin
                d_rf_we   = 1'b1;
                d_src2_ri = 1'b1;
                imm32     = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            TY_S: begin
                d_mem_wen = 1'b1;
                d_src2_ri = 1'b1;
                imm32     = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            TY_B: imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                           in_inst[30:25], in_inst[11:8], 1'b0};
            TY_U: begin
                d_rf_we = 1'b1;
                imm32   = {in_inst[31:12], 12'b0};
            end
            TY_J: begin
                d_rf_we = 1'b1;
                imm32   = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                           in_inst[20], in_inst[30:21], 1'b0};
            end
            TY_SYS: begin
                d_rf_we   = 1'b1;
                d_src2_ri = 1'b1;
            end
            default: ;
        endcase
        d_imm = DATA_WIDTH'($signed(imm32));

        if (rd == 5'd0) d_rf_we = 1'b0;
        d_ecall = (in_inst == 32'h0000_0073);
        d_mret  = (in_inst == 32'h3020_0073);
        d_csr   = (opcode == OPC_SYSTEM) && (funct3 != 3'd0);

        // Illegal entries still flow through the pipe but must cause no side effects.
        if (d_illegal) begin
            d_rf_we   = 1'b0;
            d_mem_wen = 1'b0;
            d_ecall   = 1'b0;
            d_mret    = 1'b0;
            d_csr     = 1'b0;
            d_mul     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid        <= 1'b0;
            out_pc           <= '0;
            out_rs1          <= '0;
            out_rs2          <= '0;
            out_rd           <= '0;
            out_rf_we        <= 1'b0;
            out_mem_wen      <= 1'b0;
            out_alu_src2_ri  <= 1'b0;
            out_alu_len_dw   <= 1'b0;
            out_mul_div      <= 1'b0;
            out_rf_wdata_src <= '0;
            out_npc_src      <= '0;
            out_immediate    <= '0;
            out_ecall        <= 1'b0;
            out_mret         <= 1'b0;
            out_csr_enable   <= 1'b0;
            out_illegal      <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (fire) begin
            out_valid        <= 1'b1;
            out_pc           <= in_pc;
            out_rs1          <= in_inst[19:15];
            out_rs2          <= in_inst[24:20];
            out_rd           <= rd;
            out_rf_we        <= d_rf_we;
            out_mem_wen      <= d_mem_wen;
            out_alu_src2_ri  <= d_src2_ri;
            out_alu_len_dw   <= d_dw;
            out_mul_div      <= d_mul;
            out_rf_wdata_src <= d_wsrc;
            out_npc_src      <= d_npc;
            out_immediate    <= d_imm;
            out_ecall        <= d_ecall;
            out_mret         <= d_mret;
            out_csr_enable   <= d_csr;
            out_illegal      <= d_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            decode_cnt <= '0;
        else if (out_valid && out_ready && !flush)
            decode_cnt <= decode_cnt + 32'd1;
    end

endmodule

// File: tb/tb_ysyx_040729_idu_stage.sv
// Directed self-checking bench for the decode stage: decode fields, stall,
// flush, reset and the EN_MEXT=0 variant.
module tb_ysyx_040729_idu_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_rf_we, out_mem_wen, out_alu_src2_ri, out_alu_len_dw, out_mul_div;
    logic [2:0]  out_rf_wdata_src;
    logic [1:0]  out_npc_src;
    logic [63:0] out_immediate;
    logic        out_ecall, out_mret, out_csr_enable, out_illegal;
    logic [31:0] decode_cnt;

    logic        m0_in_ready, m0_out_valid;
    logic [63:0] m0_out_pc;
    logic [4:0]  m0_rs1, m0_rs2, m0_rd;
    logic        m0_rf_we, m0_mem_wen, m0_src2_ri, m0_len_dw, m0_mul_div;
    logic [2:0]  m0_wsrc;
    logic [1:0]  m0_npc;
    logic [63:0] m0_imm;
    logic        m0_ecall, m0_mret, m0_csr, m0_illegal;
    logic [31:0] m0_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_cnt  = '0;

    ysyx_040729_idu_stage #(.INST_WIDTH(32), .DATA_WIDTH(64), .PC_WIDTH(64), .EN_MEXT(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_rf_we(out_rf_we), .out_mem_wen(out_mem_wen), .out_alu_src2_ri(out_alu_src2_ri),
        .out_alu_len_dw(out_alu_len_dw), .out_mul_div(out_mul_div),
        .out_rf_wdata_src(out_rf_wdata_src), .out_npc_src(out_npc_src),
        .out_immediate(out_immediate), .out_ecall(out_ecall), .out_mret(out_mret),
        .out_csr_enable(out_csr_enable), .out_illegal(out_illegal), .decode_cnt(decode_cnt)
    );

    ysyx_040729_idu_stage #(.INST_WIDTH(32), .DATA_WIDTH(64), .PC_WIDTH(64), .EN_MEXT(1'b0)) u_dut_nom (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(m0_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(m0_out_valid), .out_ready(out_ready),
        .out_pc(m0_out_pc), .out_rs1(m0_rs1), .out_rs2(m0_rs2), .out_rd(m0_rd),
        .out_rf_we(m0_rf_we), .out_mem_wen(m0_mem_wen), .out_alu_src2_ri(m0_src2_ri),
        .out_alu_len_dw(m0_len_dw), .out_mul_div(m0_mul_div),
        .out_rf_wdata_src(m0_wsrc), .out_npc_src(m0_npc),
        .out_immediate(m0_imm), .out_ecall(m0_ecall), .out_mret(m0_mret),
        .out_csr_enable(m0_csr), .out_illegal(m0_illegal), .decode_cnt(m0_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] inst, input logic [63:0] pc);
        @(negedge clk);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // One edge with out_ready high: the held entry retires downstream.
    task automatic retire(input string tag);
        @(posedge clk);
        #1;
        exp_cnt = exp_cnt + 32'd1;
        chk({tag, "_cnt"}, 64'(decode_cnt), 64'(exp_cnt));
        chk({tag, "_vld_drop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_inst = '0; in_pc = '0; out_ready = 1'b1;
        #12;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_cnt", 64'(decode_cnt), 64'd0);
        chk("rst_imm", out_immediate, 64'd0);
        chk("rst_rf_we", 64'(out_rf_we), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        issue(32'h0050_0093, 64'h8000_0000);
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_rf_we", 64'(out_rf_we), 64'd1);
        chk("addi_ri", 64'(out_alu_src2_ri), 64'd1);
        chk("addi_rd", 64'(out_rd), 64'd1);
        chk("addi_imm", out_immediate, 64'd5);
        chk("addi_pc", out_pc, 64'h8000_0000);
        chk("addi_illegal", 64'(out_illegal), 64'd0);
        retire("addi");

        issue(32'hFE21_AE23, 64'h8000_0004);
        chk("sw_mem_wen", 64'(out_mem_wen), 64'd1);
        chk("sw_rf_we", 64'(out_rf_we), 64'd0);
        chk("sw_rs1", 64'(out_rs1), 64'd3);
        chk("sw_rs2", 64'(out_rs2), 64'd2);
        chk("sw_imm", out_immediate, 64'hFFFF_FFFF_FFFF_FFFC);
        retire("sw");

        issue(32'h0080_00EF, 64'h8000_0008);
        chk("jal_npc", 64'(out_npc_src), 64'd1);
        chk("jal_wsrc", 64'(out_rf_wdata_src), 64'd5);
        chk("jal_imm", out_immediate, 64'd8);
        chk("jal_rf_we", 64'(out_rf_we), 64'd1);
        retire("jal");

        issue(32'hFE20_8EE3, 64'h8000_000C);
        chk("beq_npc", 64'(out_npc_src), 64'd3);
        chk("beq_imm", out_immediate, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("beq_rf_we", 64'(out_rf_we), 64'd0);
        retire("beq");

        issue(32'h0020_80BB, 64'h8000_0010);
        chk("addw_dw", 64'(out_alu_len_dw), 64'd1);
        chk("addw_rf_we", 64'(out_rf_we), 64'd1);
        chk("addw_ri", 64'(out_alu_src2_ri), 64'd0);
        retire("addw");

        issue(32'h0000_0073, 64'h8000_0014);
        chk("ecall", 64'(out_ecall), 64'd1);
        chk("ecall_csr", 64'(out_csr_enable), 64'd0);
        chk("ecall_rf_we", 64'(out_rf_we), 64'd0);
        retire("ecall");

        issue(32'h3020_0073, 64'h8000_0018);
        chk("mret", 64'(out_mret), 64'd1);
        chk("mret_ecall", 64'(out_ecall), 64'd0);
        retire("mret");

        issue(32'h3052_90F3, 64'h8000_001C);
        chk("csrrw_csr", 64'(out_csr_enable), 64'd1);
        chk("csrrw_rf_we", 64'(out_rf_we), 64'd1);
        retire("csrrw");

        issue(32'h0000_0000, 64'h8000_0020);
        chk("zero_illegal", 64'(out_illegal), 64'd1);
        chk("zero_rf_we", 64'(out_rf_we), 64'd0);
        chk("zero_valid", 64'(out_valid), 64'd1);
        retire("zero");

        issue(32'h0000_0013, 64'h8000_0024);
        chk("nop_rf_we", 64'(out_rf_we), 64'd0);
        chk("nop_illegal", 64'(out_illegal), 64'd0);
        retire("nop");

        issue(32'h0220_8033, 64'h8000_0028);
        chk("mul_mul_div", 64'(out_mul_div), 64'd1);
        chk("mul_illegal", 64'(out_illegal), 64'd0);
        chk("nom_illegal", 64'(m0_illegal), 64'd1);
        chk("nom_mul_div", 64'(m0_mul_div), 64'd0);
        retire("mul");

        // Stall: lui held for 3 cycles while a new instruction waits upstream.
        out_ready = 1'b0;
        issue(32'h1234_52B7, 64'h8000_002C);
        @(negedge clk);
        in_valid = 1'b1;
        in_inst  = 32'h0050_0093;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_rd", 64'(out_rd), 64'd5);
            chk("stall_imm", out_immediate, 64'h0000_0000_1234_5000);
            chk("stall_wsrc", 64'(out_rf_wdata_src), 64'd2);
            chk("stall_cnt", 64'(decode_cnt), 64'(exp_cnt));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_cnt  = exp_cnt + 32'd1;
        chk("release_cnt", 64'(decode_cnt), 64'(exp_cnt));
        chk("release_valid", 64'(out_valid), 64'd1);
        chk("release_rd", 64'(out_rd), 64'd1);
        retire("release");

        // Flush with a held entry and a new instruction offered.
        out_ready = 1'b0;
        issue(32'hFE21_AE23, 64'h8000_0030);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_inst  = 32'h0000_0013;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_cnt", 64'(decode_cnt), 64'(exp_cnt));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_cnt_after", 64'(decode_cnt), 64'(exp_cnt));

        // Asynchronous reset while an entry is held.
        out_ready = 1'b0;
        issue(32'h0050_0093, 64'h8000_0034);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_cnt", 64'(decode_cnt), 64'd0);
        chk("arst_rd", 64'(out_rd), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        exp_cnt   = '0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        issue(32'h0050_0093, 64'h8000_0038);
        retire("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_040729_idu_stage.md
YSYX_040729_IDU_STAGE -- requirements
Module: ysyx_040729_IDU_Stage

Interface
REQ-001 Parameter INST_WIDTH, default 32, instruction width; only 32 is supported.
REQ-002 Parameter DATA_WIDTH, default 64, immediate and XLEN width; 32 or 64.
REQ-003 Parameter PC_WIDTH, default 64, program-counter width.
REQ-004 Parameter EN_MEXT, default 1, enables M-extension decode (funct7=0000001 on OP/OP-32).
REQ-005 clk  in  1  clock; one clock domain, all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 flush  in  1  discard the held and the incoming instruction.
REQ-008 in_valid / in_ready  in / out  1 / 1  upstream (IFU) handshake.
REQ-009 in_inst / in_pc  in  INST_WIDTH / PC_WIDTH  fetched instruction and its PC.
REQ-010 out_valid / out_ready  out / in  1 / 1  downstream (EXU) handshake.
REQ-011 out_pc  out  PC_WIDTH; out_rs1, out_rs2, out_rd  out  5 each; register indices inst[19:15], [24:20], [11:7].
REQ-012 out_rf_we, out_mem_wen, out_alu_src2_ri, out_alu_len_dw, out_mul_div  out  1 each  decoded controls.
REQ-013 out_rf_wdata_src  out  3; out_npc_src  out  2; out_immediate  out  DATA_WIDTH.
REQ-014 out_ecall, out_mret, out_csr_enable, out_illegal  out  1 each.
REQ-015 decode_cnt  out  32  count of instructions accepted downstream.

Function
REQ-016 Stage holds one registered entry; in_ready SHALL be (!out_valid | out_ready) & !flush.
REQ-017 Transfer on in_valid & in_ready SHALL register the decode of in_inst; out_valid SHALL rise the next cycle (latency 1).
REQ-018 While out_valid & !out_ready, all out_* SHALL hold stable and no input SHALL be accepted.
REQ-019 flush SHALL clear out_valid next cycle regardless of out_ready or in_valid; decode_cnt SHALL not count a flushed entry.
REQ-020 decode_cnt SHALL increment by 1 on each out_valid & out_ready & !flush, wrapping from 0xFFFFFFFF to 0.
REQ-021 Opcode map {rf_wdata_src, npc_src, alu_len_dw, type}: LUI 2,0,0,U; AUIPC 4,0,0,U; JAL 5,1,0,J; JALR 5,2,0,I; BRANCH 0,3,0,B; LOAD 1,0,0,I; STORE 0,0,0,S; OP-IMM 0,0,0,I; OP 0,0,0,R; OP-IMM-32 0,0,1,I; OP-32 0,0,1,R; SYSTEM 0,0,0,SYS.
REQ-022 Type map {rf_we, mem_wen, alu_src2_ri}: R 1,0,0; I 1,0,1; S 0,1,1; B 0,0,0; U 1,0,0; J 1,0,0; SYS 1,0,1.
REQ-023 out_rf_we SHALL be forced 0 when rd==0.
REQ-024 Immediate: I sext(inst[31:20]); S sext({inst[31:25],inst[11:7]}); B sext({inst[31],inst[7],inst[30:25],inst[11:8],0}); U sext({inst[31:12],12'b0}); J sext({inst[31],inst[19:12],inst[20],inst[30:21],0}); R/SYS 0; sign-extend to DATA_WIDTH.
REQ-025 ecall iff inst==0x00000073; mret iff inst==0x30200073; csr_enable iff SYSTEM with funct3!=0.
REQ-026 out_mul_div SHALL be 1 iff EN_MEXT=1 and opcode OP/OP-32 with funct7=0000001.
REQ-027 Illegal: inst[1:0]!=11, unmapped opcode, OP-IMM-32/OP-32 when DATA_WIDTH=32, funct7=0000001 when EN_MEXT=0; then out_illegal=1 and rf_we, mem_wen, ecall, mret, csr_enable, mul_div SHALL be 0.
REQ-028 Illegal instructions SHALL still pass through the handshake and be counted.

Reset
REQ-029 On rst_n low, asynchronously: out_valid=0, decode_cnt=0, all other out_* registers=0; in_ready=1 from first cycle after release.
REQ-030 Reset mid-transfer SHALL drop the held entry with no downstream handshake completing.

Verification
REQ-031 in 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, rf_we=1, alu_src2_ri=1, rd=1, immediate=5, decode_cnt=1 after accept.
REQ-032 in 0xFE21AE23 (sw x2,-4(x3)) -> mem_wen=1, rf_we=0, rs1=3, rs2=2, immediate=0xFFFFFFFFFFFFFFFC.
REQ-033 in 0x123452B7 (lui x5,0x12345) with out_ready=0 for 3 cycles -> out_* stable, in_ready=0, immediate=0x0000000012345000, rf_wdata_src=2; released then next input accepted.
REQ-034 flush asserted with out_valid=1 and in_valid=1 -> next cycle out_valid=0, decode_cnt unchanged.
REQ-035 in 0x00000000 -> out_illegal=1, rf_we=0; in 0x00000013 (addi x0) -> rf_we=0, out_illegal=0; EN_MEXT=0 with 0x02208033 -> out_illegal=1.
REQ-036 rst_n low while out_valid=1 -> out_valid=0 immediately, decode_cnt=0.
